// File: rtl/idct_pkg.sv
// Shared types and defaults for the parametrised IDCT block-product engine.
package idct_pkg;

  typedef enum logic [1:0] {
    S_BM_IDLE,
    S_BM_RUN,
    S_BM_DRAIN,
    S_BM_DONE
  } block_mult_state_t;

  localparam logic BM_MODE_T = 1'b0;
  localparam logic BM_MODE_S = 1'b1;

  localparam int BM_N_DEF       = 8;
  localparam int BM_SHIFT_T_DEF = 8;
  localparam int BM_SHIFT_S_DEF = 16;

endpackage

// File: rtl/idct_block_mult_if.sv
// Control handshake plus operand/coefficient/result RAM ports of the block engine.
interface idct_block_mult_if
  import idct_pkg::*;
#(
  parameter int N      = BM_N_DEF,
  parameter int DATA_W = 32,
  parameter int COEF_W = 16,
  parameter int ADDR_W = 7
) ();
  localparam int IDX_W = $clog2(N * N);

  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] r_base;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] a_rd_addr;
  logic [DATA_W-1:0] a_rd_data;
  logic [IDX_W-1:0]  c_rd_index;
  logic [COEF_W-1:0] c_rd_data;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_en;

  // master = sequencer and memories, slave = the engine
  modport master (
    output start, mode, a_base, r_base, a_rd_data, c_rd_data,
    input  busy, done, a_rd_addr, c_rd_index, r_wr_addr, r_wr_data, r_wr_en
  );

  modport slave (
    input  start, mode, a_base, r_base, a_rd_data, c_rd_data,
    output busy, done, a_rd_addr, c_rd_index, r_wr_addr, r_wr_data, r_wr_en
  );

endinterface

// File: rtl/block_mult_agu.sv
// i/j/k issue counters (k innermost) and operand/coefficient address generation.
module block_mult_agu
  import idct_pkg::*;
#(
  parameter int N      = BM_N_DEF,
  parameter int ADDR_W = 7
) (
  input  logic                        CLOCK_50_I,
  input  logic                        Resetn,
  input  logic                        issue,
  input  logic                        mode,
  input  logic [ADDR_W-1:0]           a_base,
  output logic [ADDR_W-1:0]           a_rd_addr,
  output logic [$clog2(N*N)-1:0]      c_rd_index,
  output logic [$clog2(N*N)-1:0]      elem_off,
  output logic                        k_first,
  output logic                        k_last,
  output logic                        blk_last
);
  localparam int CNT_W = $clog2(N);
  localparam int IDX_W = $clog2(N * N);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

  logic [CNT_W-1:0] i_q, j_q, k_q;
  logic [IDX_W-1:0] a_off;

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (issue) begin
      if (k_q == CNT_MAX) begin
        k_q <= '0;
        if (j_q == CNT_MAX) begin
          j_q <= '0;
          i_q <= (i_q == CNT_MAX) ? '0 : i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end else begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  // N is a power of two, so row*N + col is just the concatenation
  always_comb begin
    a_off      = {i_q, k_q};
    c_rd_index = {k_q, j_q};
    if (mode == BM_MODE_S) begin
      a_off      = {k_q, j_q};
      c_rd_index = {k_q, i_q};
    end
  end

  assign a_rd_addr = a_base + ADDR_W'(a_off);
  assign elem_off  = {i_q, j_q};
  assign k_first   = (k_q == '0);
  assign k_last    = (k_q == CNT_MAX);
  assign blk_last  = (i_q == CNT_MAX) && (j_q == CNT_MAX) && (k_q == CNT_MAX);

endmodule

// File: rtl/idct_block_mult.sv
// N x N block product engine: T = A x C (mode 0) or S = C^T x A (mode 1),
// with per-mode arithmetic shift and saturation on each written element.
//   state      | meaning
//   S_BM_IDLE  | waiting for start; mode/bases latched on accept
//   S_BM_RUN   | one (i,j,k) issue per cycle
//   S_BM_DRAIN | 3 cycles flushing the MAC pipeline, last write on the final one
//   S_BM_DONE  | single-cycle done pulse, start ignored
module idct_block_mult
  import idct_pkg::*;
#(
  parameter int N       = BM_N_DEF,
  parameter int DATA_W  = 32,
  parameter int COEF_W  = 16,
  parameter int ADDR_W  = 7,
  parameter int SHIFT_T = BM_SHIFT_T_DEF,
  parameter int SHIFT_S = BM_SHIFT_S_DEF
) (
  input  logic             CLOCK_50_I,
  input  logic             Resetn,
  idct_block_mult_if.slave bus
);
  localparam int IDX_W  = $clog2(N * N);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(N);
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  block_mult_state_t state, state_nxt;
  logic [1:0]        drain_cnt;
  logic              issue, busy_c, done_c;

  logic              mode_q;
  logic [ADDR_W-1:0] a_base_q, r_base_q;

  logic              k_first, k_last, blk_last;
  logic [IDX_W-1:0]  elem_off;
  logic [ADDR_W-1:0] a_rd_addr;
  logic [IDX_W-1:0]  c_rd_index;

  logic              s1_valid, s1_first, s1_last;
  logic [IDX_W-1:0]  s1_off;
  logic              s2_valid, s2_first, s2_last;
  logic [IDX_W-1:0]  s2_off;

  logic signed [PROD_W-1:0] a_ext, c_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext, acc, acc_sum, shifted;
  logic [ACC_W-DATA_W:0]    shifted_hi;
  logic [DATA_W-1:0]        sat_res;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) state <= S_BM_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BM_IDLE:  if (bus.start) state_nxt = S_BM_RUN;
      S_BM_RUN:   if (blk_last) state_nxt = S_BM_DRAIN;
      S_BM_DRAIN: if (drain_cnt == 2'd0) state_nxt = S_BM_DONE;
      S_BM_DONE:  state_nxt = S_BM_IDLE;
      default:    state_nxt = S_BM_IDLE;
    endcase
  end

  always_comb begin
    issue  = (state == S_BM_RUN);
    busy_c = (state == S_BM_RUN) || (state == S_BM_DRAIN);
    done_c = (state == S_BM_DONE);
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      drain_cnt <= 2'd0;
    end else if (state == S_BM_RUN && state_nxt == S_BM_DRAIN) begin
      drain_cnt <= 2'd2;
    end else if (state == S_BM_DRAIN && drain_cnt != 2'd0) begin
      drain_cnt <= drain_cnt - 2'd1;
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      mode_q   <= BM_MODE_T;
      a_base_q <= '0;
      r_base_q <= '0;
    end else if (state == S_BM_IDLE && bus.start) begin
      mode_q   <= bus.mode;
      a_base_q <= bus.a_base;
      r_base_q <= bus.r_base;
    end
  end

  block_mult_agu #(.N(N), .ADDR_W(ADDR_W)) u_agu (
    .CLOCK_50_I (CLOCK_50_I),
    .Resetn     (Resetn),
    .issue      (issue),
    .mode       (mode_q),
    .a_base     (a_base_q),
    .a_rd_addr  (a_rd_addr),
    .c_rd_index (c_rd_index),
    .elem_off   (elem_off),
    .k_first    (k_first),
    .k_last     (k_last),
    .blk_last   (blk_last)
  );

  assign a_ext = $signed({{COEF_W{bus.a_rd_data[DATA_W-1]}}, bus.a_rd_data});
  assign c_ext = $signed({{DATA_W{bus.c_rd_data[COEF_W-1]}}, bus.c_rd_data});

  // Tags travel alongside the data: s1 = RAM data valid, s2 = product valid
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_off   <= '0;
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_off   <= '0;
      prod     <= '0;
    end else begin
      s1_valid <= issue;
      s1_first <= k_first;
      s1_last  <= k_last;
      s1_off   <= elem_off;
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_off   <= s1_off;
      prod     <= a_ext * c_ext;
    end
  end

  assign prod_ext   = $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
  assign acc_sum    = s2_first ? prod_ext : acc + prod_ext;
  assign shifted    = (mode_q == BM_MODE_S) ? (acc_sum >>> SHIFT_S) : (acc_sum >>> SHIFT_T);
  assign shifted_hi = shifted[ACC_W-1:DATA_W-1];

  // In range only when every bit above the result's sign bit matches it
  always_comb begin
    sat_res = shifted[DATA_W-1:0];
    if (!((&shifted_hi) || !(|shifted_hi))) begin
      sat_res = shifted[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      acc       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= s2_valid && s2_last;
      if (s2_valid) acc <= acc_sum;
      if (s2_valid && s2_last) begin
        wr_addr_q <= r_base_q + ADDR_W'(s2_off);
        wr_data_q <= sat_res;
      end
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.a_rd_addr  = a_rd_addr;
  assign bus.c_rd_index = c_rd_index;
  assign bus.r_wr_addr  = wr_addr_q;
  assign bus.r_wr_data  = wr_data_q;
  assign bus.r_wr_en    = wr_en_q;

endmodule

// File: tb/tb_idct_block_mult.sv
// Scoreboard bench for idct_block_mult: expected writes are queued at start and
// popped by a write monitor; scenario tasks check timing and boundary behaviour.
module tb_idct_block_mult;
  import idct_pkg::*;

  localparam int N       = 8;
  localparam int DATA_W  = 32;
  localparam int COEF_W  = 16;
  localparam int ADDR_W  = 7;
  localparam int SHIFT_T = 8;
  localparam int SHIFT_S = 8;
  localparam int NN      = N * N;
  localparam int MEM     = 1 << ADDR_W;
  localparam int DONE_AT = 516;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic CLOCK_50_I = 1'b0;
  logic Resetn     = 1'b0;
  always #10 CLOCK_50_I = ~CLOCK_50_I;

  idct_block_mult_if #(.N(N), .DATA_W(DATA_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W)) bus ();

  idct_block_mult #(
    .N(N), .DATA_W(DATA_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W),
    .SHIFT_T(SHIFT_T), .SHIFT_S(SHIFT_S)
  ) dut (
    .CLOCK_50_I (CLOCK_50_I),
    .Resetn     (Resetn),
    .bus        (bus)
  );

  logic [DATA_W-1:0] a_mem [MEM];
  logic [COEF_W-1:0] c_rom [NN];
  logic [DATA_W-1:0] r_mem [MEM];

  // Registered-read RAM/ROM: data valid the cycle after the address
  always @(posedge CLOCK_50_I) begin
    bus.a_rd_data <= a_mem[bus.a_rd_addr];
    bus.c_rd_data <= c_rom[bus.c_rd_index];
  end

  wr_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  wr_count = 0;
  int  prev_wr = -1;
  int  cyc = 0;
  bit  no_wr = 1'b0;

  function automatic logic [DATA_W-1:0] model_elem(bit md, logic [ADDR_W-1:0] ab, int i, int j);
    longint acc = 0;
    longint r;
    for (int k = 0; k < N; k++) begin
      logic [ADDR_W-1:0] aa;
      logic [5:0]        ci;
      if (!md) begin
        aa = ab + 7'(i * N + k);
        ci = 6'(k * N + j);
      end else begin
        aa = ab + 7'(k * N + j);
        ci = 6'(k * N + i);
      end
      acc += longint'($signed(a_mem[aa])) * longint'($signed(c_rom[ci]));
    end
    r = acc >>> (md ? SHIFT_S : SHIFT_T);
    if (r > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (r < -64'sh8000_0000) return 32'h8000_0000;
    return r[31:0];
  endfunction

  task automatic mon_loop();
    forever begin
      @(negedge CLOCK_50_I);
      cyc++;
      if (bus.r_wr_en === 1'b1) begin
        checks++;
        if (no_wr) begin
          errors++;
          $display("FAIL write_after_reset: got addr=%0d data=%h, want no write", bus.r_wr_addr, bus.r_wr_data);
        end else if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, want none", bus.r_wr_addr, bus.r_wr_data);
        end else begin
          wr_t e;
          e = sb.pop_front();
          if (bus.r_wr_addr !== e.addr || bus.r_wr_data !== e.data) begin
            errors++;
            $display("FAIL write_data: got addr=%0d data=%h, want addr=%0d data=%h",
                     bus.r_wr_addr, bus.r_wr_data, e.addr, e.data);
          end
        end
        if (prev_wr >= 0) begin
          checks++;
          if (cyc - prev_wr != N) begin
            errors++;
            $display("FAIL write_spacing: got %0d cycles, want %0d", cyc - prev_wr, N);
          end
        end
        prev_wr = cyc;
        wr_count++;
        r_mem[bus.r_wr_addr] = bus.r_wr_data;
      end
    end
  endtask

  // Called on a negedge while IDLE; returns in the first RUN cycle
  task automatic start_block(input bit md, input logic [ADDR_W-1:0] ab, input logic [ADDR_W-1:0] rb);
    sb.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        wr_t e;
        e.addr = rb + 7'(i * N + j);
        e.data = model_elem(md, ab, i, j);
        sb.push_back(e);
      end
    wr_count   = 0;
    prev_wr    = -1;
    bus.mode   = md;
    bus.a_base = ab;
    bus.r_base = rb;
    bus.start  = 1'b1;
    @(negedge CLOCK_50_I);
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 1;
    while (bus.done !== 1'b1 && cnt < 1000) begin
      @(negedge CLOCK_50_I);
      cnt++;
    end
  endtask

  task automatic set_identity(input logic [COEF_W-1:0] diag);
    for (int n = 0; n < NN; n++) c_rom[n] = (n / N == n % N) ? diag : '0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLOCK_50_I);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
    checks++; if (bus.r_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", bus.r_wr_en); end
    checks++; if (bus.a_rd_addr !== '0) begin errors++; $display("FAIL rst_a_addr: got %0d want 0", bus.a_rd_addr); end
    checks++; if (bus.c_rd_index !== '0) begin errors++; $display("FAIL rst_c_index: got %0d want 0", bus.c_rd_index); end
    checks++; if (bus.r_wr_addr !== '0) begin errors++; $display("FAIL rst_r_addr: got %0d want 0", bus.r_wr_addr); end
    checks++; if (bus.r_wr_data !== '0) begin errors++; $display("FAIL rst_r_data: got %h want 0", bus.r_wr_data); end
    Resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50_I);
  endtask

  task automatic test_identity_t();
    int cnt;
    set_identity(16'd256);
    for (int n = 0; n < MEM; n++) a_mem[n] = (n < NN) ? 32'(n) : '0;
    start_block(BM_MODE_T, 7'd0, 7'd64);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL t_busy_rise: got %b want 1", bus.busy); end
    wait_done(cnt);
    checks++; if (cnt != DONE_AT) begin errors++; $display("FAIL t_done_latency: got %0d want %0d", cnt, DONE_AT); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t_busy_fall: got %b want 0", bus.busy); end
    checks++; if (wr_count != NN) begin errors++; $display("FAIL t_write_count: got %0d want %0d", wr_count, NN); end
    for (int n = 0; n < NN; n++) begin
      checks++;
      if (r_mem[64 + n] !== 32'(n)) begin errors++; $display("FAIL t_result[%0d]: got %h want %h", n, r_mem[64 + n], 32'(n)); end
    end
    @(negedge CLOCK_50_I);
  endtask

  task automatic test_identity_s();
    int cnt;
    set_identity(16'd256);
    for (int n = 0; n < NN; n++) a_mem[64 + n] = 32'(n * 7 - 200);
    start_block(BM_MODE_S, 7'd64, 7'd0);
    cnt = 1;
    while (bus.done !== 1'b1 && cnt < 1000) begin
      if (cnt <= N * NN) begin
        int idx, i, j, k;
        idx = cnt - 1; i = idx / NN; j = (idx / N) % N; k = idx % N;
        checks++;
        if (bus.c_rd_index !== 6'(k * N + i)) begin errors++; $display("FAIL s_c_index@%0d: got %0d want %0d", cnt, bus.c_rd_index, k * N + i); end
        checks++;
        if (bus.a_rd_addr !== 7'(64 + k * N + j)) begin errors++; $display("FAIL s_a_addr@%0d: got %0d want %0d", cnt, bus.a_rd_addr, 64 + k * N + j); end
      end
      @(negedge CLOCK_50_I);
      cnt++;
    end
    checks++; if (cnt != DONE_AT) begin errors++; $display("FAIL s_done_latency: got %0d want %0d", cnt, DONE_AT); end
    for (int n = 0; n < NN; n++) begin
      checks++;
      if (r_mem[n] !== 32'(n * 7 - 200)) begin errors++; $display("FAIL s_result[%0d]: got %h want %h", n, r_mem[n], 32'(n * 7 - 200)); end
    end
    @(negedge CLOCK_50_I);
  endtask

  task automatic test_saturation();
    int cnt;
    for (int n = 0; n < MEM; n++) a_mem[n] = 32'h7FFF_FFFF;
    for (int n = 0; n < NN; n++) c_rom[n] = 16'h7FFF;
    start_block(BM_MODE_S, 7'd0, 7'd0);
    wait_done(cnt);
    checks++; if (wr_count != NN) begin errors++; $display("FAIL sat_write_count: got %0d want %0d", wr_count, NN); end
    for (int n = 0; n < NN; n++) begin
      checks++;
      if (r_mem[n] !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_pos[%0d]: got %h want 7fffffff", n, r_mem[n]); end
    end
    @(negedge CLOCK_50_I);
    for (int n = 0; n < MEM; n++) a_mem[n] = 32'hFFFF_FFFF;
    set_identity(16'd1);
    start_block(BM_MODE_T, 7'd0, 7'd64);
    wait_done(cnt);
    for (int n = 0; n < NN; n++) begin
      checks++;
      if (r_mem[64 + n] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL floor_neg[%0d]: got %h want ffffffff", n, r_mem[64 + n]); end
    end
    @(negedge CLOCK_50_I);
  endtask

  task automatic test_start_while_busy();
    int cnt;
    for (int n = 0; n < MEM; n++) a_mem[n] = 32'($urandom_range(0, 100000)) - 32'd50000;
    for (int n = 0; n < NN; n++) c_rom[n] = 16'($urandom);
    start_block(BM_MODE_T, 7'd10, 7'd64);
    cnt = 1;
    while (bus.done !== 1'b1 && cnt < 1000) begin
      if (cnt == 100) begin
        bus.start = 1'b1; bus.mode = BM_MODE_S; bus.a_base = 7'd20; bus.r_base = 7'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge CLOCK_50_I);
      cnt++;
    end
    bus.start = 1'b0;
    checks++; if (cnt != DONE_AT) begin errors++; $display("FAIL busy_start_latency: got %0d want %0d", cnt, DONE_AT); end
    checks++; if (wr_count != NN) begin errors++; $display("FAIL busy_start_writes: got %0d want %0d", wr_count, NN); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL busy_start_pending: got %0d want 0", sb.size()); end
    @(negedge CLOCK_50_I);
  endtask

  task automatic test_done_collision();
    int cnt;
    start_block(BM_MODE_S, 7'd0, 7'd0);
    wait_done(cnt);
    bus.start = 1'b1; bus.mode = BM_MODE_T; bus.a_base = 7'd5; bus.r_base = 7'd9;
    @(negedge CLOCK_50_I);
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL done_start_busy@%0d: got %b want 0", c, bus.busy); end
      @(negedge CLOCK_50_I);
    end
    checks++; if (wr_count != NN) begin errors++; $display("FAIL done_start_writes: got %0d want %0d", wr_count, NN); end
  endtask

  task automatic test_reset_mid();
    int cnt;
    set_identity(16'd256);
    for (int n = 0; n < MEM; n++) a_mem[n] = 32'(n + 1000);
    start_block(BM_MODE_T, 7'd0, 7'd64);
    cnt = 1;
    while (cnt < 300) begin @(negedge CLOCK_50_I); cnt++; end
    Resetn = 1'b0;
    no_wr  = 1'b1;
    sb.delete();
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.r_wr_en !== 1'b0) begin errors++; $display("FAIL rmid_wr_en: got %b want 0", bus.r_wr_en); end
    checks++; if (bus.a_rd_addr !== '0) begin errors++; $display("FAIL rmid_a_addr: got %0d want 0", bus.a_rd_addr); end
    checks++; if (bus.r_wr_data !== '0) begin errors++; $display("FAIL rmid_r_data: got %h want 0", bus.r_wr_data); end
    repeat (6) @(negedge CLOCK_50_I);
    Resetn = 1'b1;
    repeat (12) @(negedge CLOCK_50_I);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_after: got %b want 0", bus.busy); end
    no_wr = 1'b0;
    start_block(BM_MODE_T, 7'd0, 7'd64);
    wait_done(cnt);
    checks++; if (cnt != DONE_AT) begin errors++; $display("FAIL rmid_fresh_latency: got %0d want %0d", cnt, DONE_AT); end
    checks++; if (wr_count != NN) begin errors++; $display("FAIL rmid_fresh_writes: got %0d want %0d", wr_count, NN); end
    for (int n = 0; n < NN; n++) begin
      checks++;
      if (r_mem[64 + n] !== 32'(n + 1000)) begin errors++; $display("FAIL rmid_result[%0d]: got %h want %h", n, r_mem[64 + n], 32'(n + 1000)); end
    end
    @(negedge CLOCK_50_I);
  endtask

  task automatic test_random();
    int cnt;
    for (int b = 0; b < 50; b++) begin
      bit                md;
      logic [ADDR_W-1:0] ab, rb;
      for (int n = 0; n < MEM; n++) begin
        logic [31:0] t;
        t = $urandom;
        a_mem[n] = (b % 3 == 0) ? t : {{12{t[19]}}, t[19:0]};
      end
      for (int n = 0; n < NN; n++) c_rom[n] = 16'($urandom);
      md = 1'($urandom_range(0, 1));
      ab = (b == 0) ? 7'd112 : (b == 1) ? 7'd127 : 7'($urandom_range(0, MEM - 1));
      rb = 7'($urandom_range(0, MEM - 1));
      start_block(md, ab, rb);
      wait_done(cnt);
      checks++; if (cnt != DONE_AT) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", b, cnt, DONE_AT); end
      checks++; if (wr_count != NN) begin errors++; $display("FAIL rnd%0d_writes: got %0d want %0d", b, wr_count, NN); end
      @(negedge CLOCK_50_I);
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.mode   = 1'b0;
    bus.a_base = '0;
    bus.r_base = '0;
    for (int n = 0; n < MEM; n++) a_mem[n] = '0;
    for (int n = 0; n < NN; n++) c_rom[n] = '0;
    fork
      mon_loop();
    join_none
    test_reset();
    test_identity_t();
    test_identity_s();
    test_saturation();
    test_start_while_busy();
    test_done_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation exceeded 90000 cycles");
    $fatal(1);
  end

endmodule

// File: doc/idct_block_mult.md
Name: idct_block_mult

Overview:
- Parametrised successor to the fixed 8x8 T/S matrix engine of the IDCT datapath.
- Computes one N x N block product per start pulse, using operand RAM A, coefficient ROM C and result RAM R:
  - mode 0: T = A x C
  - mode 1: S = C^T x A
- Sits between the operand/result dual-port RAMs and the milestone FSM.
- Adds over the previous engine: runtime mode select, ping-pong base addresses, per-mode rounding shift, output saturation, busy/done handshake.

Parameters:
- N, 8, block dimension; power of two, 2..16.
- DATA_W, 32, operand and result word width (signed).
- COEF_W, 16, coefficient width (signed).
- ADDR_W, 7, RAM address width; must satisfy 2^ADDR_W >= 2*N*N.
- SHIFT_T, 8, arithmetic right shift applied to T results.
- SHIFT_S, 16, arithmetic right shift applied to S results.

Ports:
- CLOCK_50_I  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = T (A x C), 1 = S (C^T x A); latched at start.
- a_base  in  ADDR_W  base address of the A block; latched at start.
- r_base  in  ADDR_W  base address of the R block; latched at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final write.
- a_rd_addr  out  ADDR_W  operand RAM read address.
- a_rd_data  in  DATA_W  operand data; valid 1 cycle after address.
- c_rd_index  out  clog2(N*N)  coefficient ROM index.
- c_rd_data  in  COEF_W  coefficient; valid 1 cycle after index.
- r_wr_addr  out  ADDR_W  result address.
- r_wr_data  out  DATA_W  result data.
- r_wr_en  out  1  result write strobe, one cycle per element.

Behaviour:
- Reset values: busy=0, done=0, r_wr_en=0; every address and data output = 0; FSM = IDLE; all counters and the accumulator cleared.
- FSM states and transitions:
  - IDLE -> RUN when start=1. mode, a_base and r_base are latched in the same cycle.
  - RUN issues one (i,j,k) triple per cycle in row-major element order, with k innermost.
  - RUN -> DRAIN after the issue with i=j=k=N-1.
  - DRAIN lasts 3 cycles; the last element is written on its final cycle.
  - DRAIN -> DONE -> IDLE. done=1 for the single DONE cycle; busy falls in the same cycle.
- Address generation:
  - mode 0: a_rd_addr = a_base + i*N + k; c_rd_index = k*N + j.
  - mode 1: a_rd_addr = a_base + k*N + j; c_rd_index = k*N + i.
  - Address arithmetic wraps modulo 2^ADDR_W.
- Pipeline: issue at cycle t -> data at t+1 -> registered signed product at t+2 -> accumulate at t+3.
  - The accumulator is loaded, not added, on the k=0 product.
  - Accumulator width = DATA_W + COEF_W + clog2(N); no internal overflow is possible.
- Output of each element:
  - After its k=N-1 product is accumulated, result = acc >>> (mode ? SHIFT_S : SHIFT_T), rounding toward minus infinity.
  - The result is saturated to the signed DATA_W range.
  - It is written at r_base + i*N + j with r_wr_en=1 for exactly one cycle.
  - Writes are spaced N cycles apart.
- Latency: the first issue is the cycle after start is accepted. The last write is 3 cycles after the last issue, followed by done. For N=8 the total is 512 issue cycles, with done 516 cycles after the start cycle.
- Boundary conditions:
  - start while busy: ignored; latched fields are unchanged.
  - start and the DONE cycle coincide: start is ignored.
  - Resetn low mid-block: immediate return to reset values; a partial result is never written afterwards.
  - mode/a_base/r_base changing while busy: no effect.

Decomposition:
- Shared package idct_pkg:
  - block_mult_state_t enum {S_BM_IDLE, S_BM_RUN, S_BM_DRAIN, S_BM_DONE}.
  - Mode constants BM_MODE_T=1'b0, BM_MODE_S=1'b1.
  - Default N, SHIFT_T and SHIFT_S constants.
- One sub-module, block_mult_agu: the i/j/k counters plus the address and index generation for both modes. The MAC pipeline and FSM stay in the top module.

Test Plan:
- C = identity scaled by 256 (c=256 on the diagonal), mode 0, A[n]=n (n=0..63), a_base=0, r_base=64, N=8 -> R[64+n]=n for all 64 elements. done exactly 516 cycles after start; r_wr_en pulses every 8 cycles.
- Same C, mode 1, SHIFT_S=8, a_base=64, r_base=0 -> R[n] = A[64+n]. Index pattern checked: c_rd_index = k*8+i.
- A all 0x7FFFFFFF, C all 0x7FFF, mode 1 -> every result saturated to 0x7FFFFFFF. A all -1, C=1 on diagonal, mode 0 -> -1 >>> 8 = -1.
- Second start pulse at cycle 100 with a different mode and base -> ignored; the first block completes unchanged, with exactly 64 writes.
- Resetn asserted at cycle 300 and released -> no writes after the assert, busy=0. A fresh start then completes a full block correctly.
- Random A, C and mode over 50 blocks, checked against a reference model; includes a_base=112, which checks wrap-around at 2^ADDR_W.
